// File: rtl/tdm_demux16.sv
// tdm_demux16: 16-slot TDM receive demux; build with TDM_DEMUX_PARITY_EN for a 17th even-parity slot and a parity_err output
module tdm_demux16 #(
  parameter int DW = 1,
  parameter int NCH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [3:0]        ch_sel,
  output logic [NCH*DW-1:0] y,
  output logic              frame_valid,
  output logic              frame_err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int CW = 5;
  localparam logic [CW-1:0] LAST = CW'(NCH);
`else
  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
`endif
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic {HUNT, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NCH-1:0][DW-1:0] work;
`ifdef TDM_DEMUX_PARITY_EN
  // Slot 16 is shown as 4'hF; the counter's top bit tells it apart from slot 15
  assign ch_sel = cnt[4] ? 4'hF : cnt[3:0];
`else
  assign ch_sel = cnt;
`endif
  // Framing FSM: hunt for sof, fill slots, publish y only on a complete frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= HUNT;
      cnt         <= '0;
      work        <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (din_valid) begin
        if (state == HUNT) begin
          if (sof) begin
            work[0] <= din;
            cnt     <= ONE;
            state   <= RUN;
          end
        end else if (sof) begin
          frame_err <= cnt != '0;
          work[0]   <= din;
          cnt       <= ONE;
        end else if (cnt == '0) begin
          frame_err <= 1'b1;
          state     <= HUNT;
        end else if (cnt == LAST) begin
`ifdef TDM_DEMUX_PARITY_EN
          if ((^work) == din[0]) begin
            y           <= work;
            frame_valid <= 1'b1;
          end else
            parity_err  <= 1'b1;
`else
          y           <= {din, work[NCH-2:0]};
          frame_valid <= 1'b1;
`endif
          cnt <= '0;
        end else begin
          work[cnt[3:0]] <= din;
          cnt            <= cnt + ONE;
        end
      end
    end
endmodule
